// File: rtl/ccsds_derand_stream_if.sv
// Byte-stream bundle for the CCSDS derandomiser.
// Upstream beat, downstream beat and both handshakes.
interface ccsds_derand_stream_if #(
  parameter int W = 1
);
  logic           cvcdu_new;
  logic [8*W-1:0] data_in;
  logic           data_valid_in;
  logic           data_ready_out;
  logic [8*W-1:0] data_out;
  logic [8*W-1:0] noise_out;
  logic           data_valid_out;
  logic           data_ready_in;
  logic           frame_last_out;
  logic           overrun_out;

  modport master (
    output cvcdu_new,
    output data_in,
    output data_valid_in,
    output data_ready_in,
    input  data_ready_out,
    input  data_out,
    input  noise_out,
    input  data_valid_out,
    input  frame_last_out,
    input  overrun_out
  );

  modport slave (
    input  cvcdu_new,
    input  data_in,
    input  data_valid_in,
    input  data_ready_in,
    output data_ready_out,
    output data_out,
    output noise_out,
    output data_valid_out,
    output frame_last_out,
    output overrun_out
  );
endinterface

// File: rtl/ccsds_derand_stream.sv
// CCSDS PN derandomiser, BYTES_PER_BEAT bytes per beat,
// with CVCDU position tracking and a one-deep output register.
module ccsds_derand_stream #(
  parameter int         BYTES_PER_BEAT = 1,
  parameter int         FRAME_BYTES    = 1020,
  parameter logic [7:0] POLY           = 8'hA9,
  parameter logic [7:0] SEED           = 8'hFF
) (
  input logic                  clk_in,
  input logic                  rst_in,
  ccsds_derand_stream_if.slave io
);
  localparam int W  = BYTES_PER_BEAT;
  localparam int NB = 8 * W;
  localparam int CW = $clog2(FRAME_BYTES + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FRAME_END = cnt_t'(FRAME_BYTES);
  localparam cnt_t LAST_BASE = cnt_t'(FRAME_BYTES - W);
  localparam cnt_t STEP      = cnt_t'(W);

  logic [7:0]    lfsr;
  cnt_t          cnt;
  logic          accept;
  logic [7:0]    st_start;
  logic [7:0]    st_next;
  logic [7:0]    walk;
  logic [NB-1:0] noise;
  cnt_t          base;
  cnt_t          base_next;
  logic          is_last;
  logic          is_over;

  assign io.data_ready_out = !io.data_valid_out
                          || io.data_ready_in;
  assign accept = io.data_valid_in
               && io.data_ready_out;

  assign st_start = io.cvcdu_new ? SEED : lfsr;
  assign base     = io.cvcdu_new ? '0 : cnt;

  // walk[0] is the next PN bit; the tap mask selects
  // the sequence terms that form the bit 8 steps ahead
  always_comb begin
    walk  = st_start;
    noise = '0;
    for (int k = 0; k < NB; k++) begin
      noise[NB-1-k] = walk[0];
      walk = {^(walk & POLY), walk[7:1]};
    end
    st_next = walk;
  end

  assign is_last   = (base == LAST_BASE);
  assign is_over   = (base >= FRAME_END);
  assign base_next = is_over ? FRAME_END
                             : base + STEP;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lfsr              <= SEED;
      cnt               <= '0;
      io.data_valid_out <= 1'b0;
      io.data_out       <= '0;
      io.noise_out      <= '0;
      io.frame_last_out <= 1'b0;
      io.overrun_out    <= 1'b0;
    end else if (accept) begin
      lfsr              <= st_next;
      cnt               <= base_next;
      io.data_valid_out <= 1'b1;
      io.data_out       <= io.data_in ^ noise;
      io.noise_out      <= noise;
      io.frame_last_out <= is_last;
      io.overrun_out    <= is_over;
    end else if (io.data_ready_in) begin
      io.data_valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ccsds_derand_stream.sv
// Bench for ccsds_derand_stream: W=1 and W=4 instances
// against a PN model built from the h(x) recurrence.
module tb_ccsds_derand_stream;
  localparam int FB = 1020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccsds_derand_stream_if #(.W(1)) a ();
  ccsds_derand_stream_if #(.W(4)) b ();

  ccsds_derand_stream #(
    .BYTES_PER_BEAT(1),
    .FRAME_BYTES(FB)
  ) dut1 (
    .clk_in(clk),
    .rst_in(rst),
    .io(a)
  );

  ccsds_derand_stream #(
    .BYTES_PER_BEAT(4),
    .FRAME_BYTES(FB)
  ) dut4 (
    .clk_in(clk),
    .rst_in(rst),
    .io(b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] pn [0:254];
  bit new_mask [0:4095];
  int last_seen [$];
  int ovr_seen [$];
  logic [7:0] noise_seen [$];
  int pos1 = 0;

  // a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n], a[0..7]=1
  task automatic build_pn();
    bit s [0:2047];
    for (int i = 0; i < 8; i++) s[i] = 1'b1;
    for (int i = 8; i < 2048; i++)
      s[i] = s[i-1] ^ s[i-3] ^ s[i-5] ^ s[i-8];
    for (int j = 0; j < 255; j++)
      for (int k = 0; k < 8; k++)
        pn[j][7-k] = s[8*j+k];
  endtask

  function automatic logic [7:0] pn_at(input int i);
    return pn[i % 255];
  endfunction

  task automatic clear_mask();
    for (int i = 0; i < 4096; i++) new_mask[i] = 1'b0;
  endtask

  task automatic test_reset();
    a.data_valid_in = 1'b0;
    a.cvcdu_new     = 1'b0;
    a.data_in       = '0;
    a.data_ready_in = 1'b0;
    b.data_valid_in = 1'b0;
    b.cvcdu_new     = 1'b0;
    b.data_in       = '0;
    b.data_ready_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a.data_valid_out, a.frame_last_out, a.overrun_out,
         a.data_out, a.noise_out} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_w1: got v=%b l=%b o=%b d=%h n=%h want all 0",
               a.data_valid_out, a.frame_last_out, a.overrun_out,
               a.data_out, a.noise_out);
    end
    n_cmp++;
    if ({b.data_valid_out, b.frame_last_out, b.overrun_out,
         b.data_out, b.noise_out} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_w4: got v=%b d=%h n=%h want all 0",
               b.data_valid_out, b.data_out, b.noise_out);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (a.data_ready_out !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_w1: got %b want 1", a.data_ready_out);
    end
    n_cmp++;
    if (b.data_ready_out !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_w4: got %b want 1", b.data_ready_out);
    end
  endtask

  task automatic test_pn_vector();
    logic [7:0] tbl [16];
    tbl = '{8'hFF, 8'h48, 8'h0E, 8'hC0, 8'h9A, 8'h0D, 8'h70, 8'hBC,
            8'h8E, 8'h2C, 8'h93, 8'hAD, 8'hA7, 8'hB7, 8'h46, 8'hCE};
    a.data_ready_in = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_cmp++;
        if (a.data_valid_out !== 1'b0) begin
          n_bad++;
          $display("FAIL pn_idle: got v=%b want 0", a.data_valid_out);
        end
      end else begin
        n_cmp++;
        if ({a.data_valid_out, a.data_out, a.noise_out}
            !== {1'b1, tbl[i-1], tbl[i-1]}) begin
          n_bad++;
          $display("FAIL pn_vec[%0d]: got v=%b d=%h n=%h want v=1 d=%h",
                   i-1, a.data_valid_out, a.data_out, a.noise_out,
                   tbl[i-1]);
        end
        n_cmp++;
        if (a.data_out !== pn_at(i-1)) begin
          n_bad++;
          $display("FAIL pn_model[%0d]: got %h want %h",
                   i-1, a.data_out, pn_at(i-1));
        end
      end
      a.data_valid_in = (i < 16);
      a.cvcdu_new     = (i == 0);
      a.data_in       = 8'h00;
    end
    @(negedge clk);
    n_cmp++;
    if (a.data_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL pn_drain: got v=%b want 0", a.data_valid_out);
    end
    pos1 = 16;
  endtask

  task automatic test_w4();
    int p;
    logic [31:0] ed;
    logic el, eo;
    b.data_ready_in = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) begin
        p  = 4 * (i - 1);
        ed = {pn_at(p), pn_at(p+1), pn_at(p+2), pn_at(p+3)};
        el = (p <= FB - 1) && (p + 3 >= FB - 1);
        eo = (p >= FB);
        n_cmp++;
        if ({b.data_valid_out, b.frame_last_out, b.overrun_out,
             b.data_out, b.noise_out} !== {1'b1, el, eo, ed, ed}) begin
          n_bad++;
          $display("FAIL w4_beat[%0d]: got v=%b l=%b o=%b d=%h want v=1 l=%b o=%b d=%h",
                   i-1, b.data_valid_out, b.frame_last_out,
                   b.overrun_out, b.data_out, el, eo, ed);
        end
        if (i == 1) begin
          n_cmp++;
          if (b.data_out !== 32'hFF480EC0) begin
            n_bad++;
            $display("FAIL w4_first: got %h want ff480ec0", b.data_out);
          end
        end
        if (i == 2) begin
          n_cmp++;
          if (b.data_out !== 32'h9A0D70BC) begin
            n_bad++;
            $display("FAIL w4_second: got %h want 9a0d70bc", b.data_out);
          end
        end
        if (i == 64) begin
          n_cmp++;
          if (b.data_out[7:0] !== 8'hFF) begin
            n_bad++;
            $display("FAIL w4_byte255: got %h want ff", b.data_out[7:0]);
          end
        end
      end
      b.data_valid_in = (i < 256);
      b.cvcdu_new     = (i == 0);
      b.data_in       = '0;
    end
    b.data_valid_in = 1'b0;
  endtask

  task automatic run_w1(input int nbeats, input int rdy_pct,
                        input int vld_pct);
    logic [7:0] qd [$];
    logic [7:0] qn [$];
    bit ql [$];
    bit qo [$];
    logic [18:0] snap;
    logic [7:0] nz;
    bit holding, rdy, go;
    bit stalled = 1'b0;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    last_seen.delete();
    ovr_seen.delete();
    noise_seen.delete();
    while (got < nbeats && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      holding = (qd.size() > 0);
      n_cmp++;
      if (a.data_valid_out !== holding) begin
        n_bad++;
        $display("FAIL stream_valid cyc %0d: got %b want %b",
                 cyc, a.data_valid_out, holding);
      end
      if (stalled) begin
        n_cmp++;
        if ({a.data_valid_out, a.data_out, a.noise_out,
             a.frame_last_out, a.overrun_out} !== snap) begin
          n_bad++;
          $display("FAIL stall_hold cyc %0d: got %h want %h", cyc,
                   {a.data_valid_out, a.data_out, a.noise_out,
                    a.frame_last_out, a.overrun_out}, snap);
        end
      end
      a.data_ready_in = ($urandom_range(99) < rdy_pct);
      rdy = !holding || a.data_ready_in;
      go  = (sent < nbeats) && ($urandom_range(99) < vld_pct);
      a.data_valid_in = go;
      a.data_in       = 8'($urandom);
      a.cvcdu_new     = (go && rdy) ? new_mask[sent]
                                    : 1'($urandom_range(1));
      #1;
      n_cmp++;
      if (a.data_ready_out !== rdy) begin
        n_bad++;
        $display("FAIL stream_ready cyc %0d: got %b want %b",
                 cyc, a.data_ready_out, rdy);
      end
      if (holding && a.data_ready_in) begin
        n_cmp++;
        if ({a.data_out, a.noise_out, a.frame_last_out, a.overrun_out}
            !== {qd[0], qn[0], ql[0], qo[0]}) begin
          n_bad++;
          $display("FAIL beat %0d: got d=%h n=%h l=%b o=%b want d=%h n=%h l=%b o=%b",
                   got, a.data_out, a.noise_out, a.frame_last_out,
                   a.overrun_out, qd[0], qn[0], ql[0], qo[0]);
        end
        if (a.frame_last_out === 1'b1) last_seen.push_back(got);
        if (a.overrun_out === 1'b1) ovr_seen.push_back(got);
        noise_seen.push_back(a.noise_out);
        void'(qd.pop_front());
        void'(qn.pop_front());
        void'(ql.pop_front());
        void'(qo.pop_front());
        got++;
      end
      stalled = holding && !a.data_ready_in;
      snap = {a.data_valid_out, a.data_out, a.noise_out,
              a.frame_last_out, a.overrun_out};
      if (go && rdy) begin
        if (a.cvcdu_new) pos1 = 0;
        nz = pn_at(pos1);
        qd.push_back(a.data_in ^ nz);
        qn.push_back(nz);
        ql.push_back(pos1 == FB - 1);
        qo.push_back(pos1 >= FB);
        pos1++;
        sent++;
      end
    end
    a.data_valid_in = 1'b0;
    a.cvcdu_new     = 1'b0;
    a.data_ready_in = 1'b1;
    if (got < nbeats) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d beats want %0d", got, nbeats);
    end
    @(negedge clk);
  endtask

  task automatic test_frame_len();
    clear_mask();
    new_mask[0] = 1'b1;
    run_w1(1021, 100, 100);
    n_cmp++;
    if (last_seen.size() != 1 || last_seen[0] != 1019) begin
      n_bad++;
      $display("FAIL frame_last: got n=%0d first=%0d want n=1 at 1019",
               last_seen.size(), last_seen[0]);
    end
    n_cmp++;
    if (ovr_seen.size() != 1 || ovr_seen[0] != 1020) begin
      n_bad++;
      $display("FAIL overrun: got n=%0d first=%0d want n=1 at 1020",
               ovr_seen.size(), ovr_seen[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_mask();
    new_mask[0]    = 1'b1;
    new_mask[1020] = 1'b1;
    new_mask[2040] = 1'b1;
    run_w1(3060, 50, 70);
    n_cmp++;
    if (last_seen.size() != 3 || last_seen[0] != 1019 ||
        last_seen[1] != 2039 || last_seen[2] != 3059) begin
      n_bad++;
      $display("FAIL bp_last: got n=%0d want 3 at 1019/2039/3059",
               last_seen.size());
    end
    n_cmp++;
    if (ovr_seen.size() != 0) begin
      n_bad++;
      $display("FAIL bp_overrun: got n=%0d want 0", ovr_seen.size());
    end
  endtask

  task automatic test_resync();
    clear_mask();
    new_mask[0]   = 1'b1;
    new_mask[100] = 1'b1;
    run_w1(1200, 100, 100);
    n_cmp++;
    if (noise_seen[100] !== 8'hFF) begin
      n_bad++;
      $display("FAIL resync_noise: got %h want ff", noise_seen[100]);
    end
    n_cmp++;
    if (last_seen.size() != 1 || last_seen[0] != 1119) begin
      n_bad++;
      $display("FAIL resync_last: got n=%0d first=%0d want n=1 at 1119",
               last_seen.size(), last_seen[0]);
    end
    n_cmp++;
    if (ovr_seen.size() != 80 || ovr_seen[0] != 1120) begin
      n_bad++;
      $display("FAIL resync_overrun: got n=%0d first=%0d want 80 from 1120",
               ovr_seen.size(), ovr_seen[0]);
    end
  endtask

  task automatic test_reset_mid();
    a.data_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a.data_valid_in = 1'b1;
      a.cvcdu_new     = (i == 0);
      a.data_in       = 8'($urandom);
    end
    @(negedge clk);
    a.data_valid_in = 1'b0;
    a.cvcdu_new     = 1'b0;
    a.data_ready_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a.data_valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_held: got v=%b want 1", a.data_valid_out);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({a.data_valid_out, a.data_out} !== 9'd0) begin
      n_bad++;
      $display("FAIL rstmid_flush: got v=%b d=%h want 0",
               a.data_valid_out, a.data_out);
    end
    a.data_valid_in = 1'b1;
    a.cvcdu_new     = 1'b0;
    a.data_in       = 8'h5A;
    @(negedge clk);
    n_cmp++;
    if ({a.data_valid_out, a.noise_out, a.data_out,
         a.frame_last_out, a.overrun_out}
        !== {1'b1, 8'hFF, 8'hA5, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_restart: got v=%b n=%h d=%h l=%b o=%b want v=1 n=ff d=a5 l=0 o=0",
               a.data_valid_out, a.noise_out, a.data_out,
               a.frame_last_out, a.overrun_out);
    end
    a.data_valid_in = 1'b0;
    a.data_ready_in = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_pn();
    test_reset();
    test_pn_vector();
    test_w4();
    test_frame_len();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
